uart_rx: RTL

- Serial receiver for the host link, opposite direction of the transmit path.
- Deserializes 8N1 UART frames from the rx pin and pushes each completed byte into the RX FIFO through its we/w_data/full write interface.
- Flags framing errors and overruns to the status logic.
- Bit timing comes from a fixed clocks-per-bit count with mid-bit sampling.

---
 rtl/uart_rx.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized input, mid-bit sampling from a fixed
// clocks-per-bit count, bytes pushed to the RX FIFO write port with error pulses.
module uart_rx #(
   parameter int CLKS_PER_BIT    = 868,
   parameter int FIFO_DATA_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx,
   input  logic                       full,
   output logic                       we,
   output logic [FIFO_DATA_WIDTH-1:0] w_data,
   output logic                       frame_err,
   output logic                       overrun_err,
   output logic                       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(FIFO_DATA_WIDTH) + 1;
   localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(FIFO_DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;

   state_t                     state, state_n;
   logic                       rx_m, rx_s;
   logic [CW-1:0]              cnt, cnt_n;
   logic [IW-1:0]              idx, idx_n;
   logic [FIFO_DATA_WIDTH-1:0] shreg, shreg_n, w_data_n;
   logic                       we_n, frame_err_n, overrun_err_n;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m        <= 1'b1;
         rx_s        <= 1'b1;
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         w_data      <= '0;
         we          <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         rx_m        <= rx;
         rx_s        <= rx_m;
         state       <= state_n;
         cnt         <= cnt_n;
         idx         <= idx_n;
         shreg       <= shreg_n;
         w_data      <= w_data_n;
         we          <= we_n;
         frame_err   <= frame_err_n;
         overrun_err <= overrun_err_n;
      end
   end

   always_comb begin
      state_n       = state;
      cnt_n         = cnt;
      idx_n         = idx;
      shreg_n       = shreg;
      w_data_n      = w_data;
      we_n          = 1'b0;
      frame_err_n   = 1'b0;
      overrun_err_n = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == HALF_CNT) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == BIT_CNT) begin
               cnt_n   = '0;
               shreg_n = {rx_s, shreg[FIFO_DATA_WIDTH-1:1]};
               idx_n   = idx + 1'b1;
               if (idx == LAST_IDX) state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            // Decide at stop-bit mid-point so a back-to-back start edge is seen.
            if (cnt == BIT_CNT) begin
               cnt_n = '0;
               if (rx_s) begin
                  state_n = IDLE;
                  if (full) begin
                     overrun_err_n = 1'b1;
                  end else begin
                     we_n     = 1'b1;
                     w_data_n = shreg;
                  end
               end else begin
                  frame_err_n = 1'b1;
                  state_n     = RECOVER;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RECOVER: begin
            cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule
